divider_stream_ctrl: RTL
========================

Name: divider_stream_ctrl

Overview:
- Streaming front end for the shared sequential divider in the FM radio datapath.
- Pops {numerator, denominator} pairs from an upstream first-word-fall-through (FWFT) FIFO and pre-scales the numerator to fixed point.
- Issues one divide at a time, waits for completion, and pushes the quotient into a downstream FIFO.
- Tracks divide-by-zero results and guards against a hung divider with a watchdog.

Parameters:
- DATA_WIDTH, 32, width of numerator, denominator and quotient.
- QUANT_BITS, 10, left shift applied to the numerator before division (fixed-point quotient).
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before a fault is declared.
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_empty  in  1  upstream FIFO empty
- in_dout  in  2*DATA_WIDTH  FWFT head word: numerator in the upper half, denominator in the lower half
- in_rd_en  out  1  pop upstream FIFO
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  push downstream FIFO
- out_din  out  DATA_WIDTH  quotient word
- div_start  out  1  one-cycle start pulse to the divider
- div_numerator  out  DATA_WIDTH  registered divider numerator
- div_denominator  out  DATA_WIDTH  registered divider denominator
- div_quotient  in  DATA_WIDTH  divider quotient
- div_error  in  1  divider divide-by-zero flag
- div_done  in  1  divider completion pulse
- busy  out  1  high in any state other than IDLE
- fault  out  1  sticky watchdog fault
- err_count  out  ERR_CNT_WIDTH  saturating count of div_error results

Behaviour:
- Reset and clock: reset reset, asynchronous, active-high; clock clock. Reset clears all registers and outputs to 0 and the state to IDLE.
- Reset mid-operation: the in-flight sample is lost; the divider is reset on the same net.
- States: IDLE, ISSUE, WAIT, WRITE, FAULT.
- IDLE:
  - If in_empty=0: in_rd_en=1 for exactly one cycle.
  - Latch div_numerator = signed(in_dout upper half) <<< QUANT_BITS, truncated to DATA_WIDTH, two's-complement wrap, no overflow check.
  - Latch div_denominator = lower half.
  - Go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle; watchdog counter cleared; go to WAIT.
- Operand hold: div_numerator and div_denominator stay constant from ISSUE until the cycle after div_done. The divider reads the operand signs in its final state.
- WAIT:
  - Counter increments on each cycle without div_done.
  - On div_done: capture result (div_quotient, or the error value if div_error=1); if div_error=1, err_count increments, saturating at all-ones; go to WRITE.
  - If the counter reaches TIMEOUT_CYCLES-1 and div_done=0: go to FAULT.
  - div_done and timeout in the same cycle: done wins.
- WRITE:
  - If out_full=0: out_wr_en=1 for one cycle, out_din=result, go to IDLE.
  - Otherwise hold, with out_wr_en=0 and no upstream pop.
- FAULT:
  - fault=1, sticky until reset.
  - in_rd_en, div_start and out_wr_en stay 0; busy=1.
- div_done while not in WAIT: ignored.
- Latency: minimum in_rd_en to out_wr_en = 3 + divider latency cycles. One sample in flight at a time; order preserved.
- out_din: registered, holds its last value between writes.

Optional Feature:
- Macro DIV_SAT_EN.
- Defined: a div_error result writes a saturated value: 2^(DATA_WIDTH-1)-1 if the original numerator is ≥ 0, else -2^(DATA_WIDTH-1).
- Undefined: a div_error result writes 0.
- err_count behaves identically in both builds.

Test Plan:
- Basic divide: push {3, 2} → div_numerator=3072, div_denominator=2; divider model returns 1536 → single out_wr_en with out_din=1536.
- Negative numerator: push {0xFFFFFFFB, 2} → div_numerator=0xFFFFEC00; model returns 0xFFFFF600 → out_din=0xFFFFF600.
- Divide by zero: push {7, 0}, model asserts div_error+div_done → out_din=0 (0x7FFFFFFF with DIV_SAT_EN), err_count=1; push {-7, 0} with DIV_SAT_EN → out_din=0x80000000, err_count=2.
- Backpressure: out_full held 1 for 10 cycles after done → out_wr_en=0 and in_rd_en=0 throughout; write occurs the cycle out_full drops.
- Watchdog: TIMEOUT_CYCLES=64, model never asserts done → fault=1 after 64 WAIT cycles; no out_wr_en; in_rd_en stays 0 with a non-empty FIFO until reset; after reset, fault=0 and operation resumes.
- Back-to-back: 4 pairs queued, done asserted at random delays (including a done in the same cycle the timeout would fire) → exactly 4 pops and 4 pushes, in order, one div_start per pair.

Source files
------------

// File: rtl/divider_stream_ctrl.sv
// Streaming front end for the shared sequential divider: pops operand pairs, issues one divide at a time,
// pushes quotients downstream. Optional macro DIV_SAT_EN: divide-by-zero results saturate instead of writing 0.
module divider_stream_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int QUANT_BITS     = 10,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_empty,
  input  logic [2*DATA_WIDTH-1:0]    in_dout,
  output logic                       in_rd_en,
  input  logic                       out_full,
  output logic                       out_wr_en,
  output logic [DATA_WIDTH-1:0]      out_din,
  output logic                       div_start,
  output logic [DATA_WIDTH-1:0]      div_numerator,
  output logic [DATA_WIDTH-1:0]      div_denominator,
  input  logic [DATA_WIDTH-1:0]      div_quotient,
  input  logic                       div_error,
  input  logic                       div_done,
  output logic                       busy,
  output logic                       fault,
  output logic [ERR_CNT_WIDTH-1:0]   err_count
);

  localparam int WD_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_FAULT
  } state_t;

  state_t                    state_q;
  logic                      inRdEn_q;
  logic                      divStart_q;
  logic                      outWrEn_q;
  logic [DATA_WIDTH-1:0]     divNum_q;
  logic [DATA_WIDTH-1:0]     divDen_q;
  logic [DATA_WIDTH-1:0]     result_q;
  logic [DATA_WIDTH-1:0]     outDin_q;
  logic                      busy_q;
  logic                      fault_q;
  logic [ERR_CNT_WIDTH-1:0]  errCount_q;
  logic [WD_WIDTH-1:0]       wdCount_q;
`ifdef DIV_SAT_EN
  logic                      numNeg_q;
`endif

  logic [DATA_WIDTH-1:0]     inNum;
  logic [DATA_WIDTH-1:0]     inDen;
  logic [DATA_WIDTH-1:0]     scaledNum;
  logic [DATA_WIDTH-1:0]     result_d;
  logic [ERR_CNT_WIDTH-1:0]  errCount_d;

  assign inNum     = in_dout[2*DATA_WIDTH-1:DATA_WIDTH];
  assign inDen     = in_dout[DATA_WIDTH-1:0];
  // Fixed-point pre-scale; overflow wraps silently in two's complement.
  assign scaledNum = inNum << QUANT_BITS;

  always_comb begin
    errCount_d = (&errCount_q) ? errCount_q : errCount_q + 1'b1;
    result_d   = div_quotient;
    if (div_error) begin
`ifdef DIV_SAT_EN
      result_d = numNeg_q ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
      result_d = '0;
`endif
    end
  end

  // Operands only change in IDLE, so they stay stable for the divider until after its done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      inRdEn_q   <= 1'b0;
      divStart_q <= 1'b0;
      outWrEn_q  <= 1'b0;
      divNum_q   <= '0;
      divDen_q   <= '0;
      result_q   <= '0;
      outDin_q   <= '0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      errCount_q <= '0;
      wdCount_q  <= '0;
`ifdef DIV_SAT_EN
      numNeg_q   <= 1'b0;
`endif
    end else begin
      inRdEn_q   <= 1'b0;
      divStart_q <= 1'b0;
      outWrEn_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!in_empty) begin
            inRdEn_q   <= 1'b1;
            divStart_q <= 1'b1;
            divNum_q   <= scaledNum;
            divDen_q   <= inDen;
`ifdef DIV_SAT_EN
            numNeg_q   <= inNum[DATA_WIDTH-1];
`endif
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wdCount_q <= '0;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (div_done) begin
            result_q <= result_d;
            if (div_error) begin
              errCount_q <= errCount_d;
            end
            state_q <= ST_WRITE;
          end else if (wdCount_q == WD_LAST) begin
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end else begin
            wdCount_q <= wdCount_q + 1'b1;
          end
        end
        ST_WRITE: begin
          if (!out_full) begin
            outWrEn_q <= 1'b1;
            outDin_q  <= result_q;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          fault_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_rd_en        = inRdEn_q;
  assign div_start       = divStart_q;
  assign out_wr_en       = outWrEn_q;
  assign out_din         = outDin_q;
  assign div_numerator   = divNum_q;
  assign div_denominator = divDen_q;
  assign busy            = busy_q;
  assign fault           = fault_q;
  assign err_count       = errCount_q;

endmodule
